// File: rtl/i2c_cfg_seq.sv
// Table-driven I2C register configuration sequencer: walks a ROM of {register, data}
// entries and issues each one to an I2C driver, with optional read-back verify and retries.
module i2c_cfg_seq #(
  parameter int         NUM_ENTRIES = 16,
  parameter logic [7:0] DEV_ADDR    = 8'h78,
  parameter int         MAX_RETRY   = 3,
  parameter int         PWR_WAIT    = 1000,
  parameter bit         VERIFY      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        cfg_start,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        start_en,
  output logic        wr_rd_flag,
  output logic [7:0]  i2c_device_addr,
  output logic [15:0] register,
  output logic [7:0]  data_byte,
  input  logic        busy,
  input  logic        err,
  input  logic [7:0]  rd_data,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_fail,
  output logic [7:0]  fail_index,
  output logic [3:0]  fsm_state
);

  // Handshake with the driver: start_en is a one-cycle request, only raised while busy is low.
  // The driver answers by raising busy; the result (err, rd_data) is valid once busy falls.
  // If busy never rises within 8 cycles of the request, the attempt is treated as failed.

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_LATCH, S_ISSUE,
    S_WAIT_HI, S_WAIT_LO, S_CHECK, S_DONE, S_FAIL
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0]  MAX_R    = 8'(MAX_RETRY);
  localparam logic [31:0] PWR_LAST = (PWR_WAIT > 0) ? 32'(PWR_WAIT - 1) : 32'd0;

  state_t      state, state_n;
  logic [7:0]  entry_idx, entry_idx_n;
  logic [7:0]  retry, retry_n;
  logic [31:0] pwr_cnt, pwr_cnt_n;
  logic [2:0]  to_cnt, to_cnt_n;
  logic [15:0] register_n;
  logic [7:0]  data_byte_n;
  logic        wr_rd_n;
  logic        done_n, fail_n;
  logic [7:0]  fail_index_n;
  logic        att_pass, att_fail;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      entry_idx  <= '0;
      retry      <= '0;
      pwr_cnt    <= '0;
      to_cnt     <= '0;
      register   <= '0;
      data_byte  <= '0;
      wr_rd_flag <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_fail   <= 1'b0;
      fail_index <= '0;
    end else begin
      state      <= state_n;
      entry_idx  <= entry_idx_n;
      retry      <= retry_n;
      pwr_cnt    <= pwr_cnt_n;
      to_cnt     <= to_cnt_n;
      register   <= register_n;
      data_byte  <= data_byte_n;
      wr_rd_flag <= wr_rd_n;
      cfg_done   <= done_n;
      cfg_fail   <= fail_n;
      fail_index <= fail_index_n;
    end
  end

  always_comb begin
    state_n      = state;
    entry_idx_n  = entry_idx;
    retry_n      = retry;
    pwr_cnt_n    = pwr_cnt;
    to_cnt_n     = to_cnt;
    register_n   = register;
    data_byte_n  = data_byte;
    wr_rd_n      = wr_rd_flag;
    done_n       = cfg_done;
    fail_n       = cfg_fail;
    fail_index_n = fail_index;
    start_en     = 1'b0;
    att_pass     = 1'b0;
    att_fail     = 1'b0;

    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_n      = S_PWR;
          done_n       = 1'b0;
          fail_n       = 1'b0;
          fail_index_n = '0;
          entry_idx_n  = '0;
          retry_n      = '0;
          pwr_cnt_n    = '0;
        end
      end
      S_PWR: begin
        if (pwr_cnt >= PWR_LAST) state_n = S_FETCH;
        else                     pwr_cnt_n = pwr_cnt + 32'd1;
      end
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        register_n  = rom_data[23:8];
        data_byte_n = rom_data[7:0];
        wr_rd_n     = 1'b0;
        state_n     = S_ISSUE;
      end
      S_ISSUE: begin
        if (!busy) begin
          start_en = 1'b1;
          to_cnt_n = '0;
          state_n  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (busy)                 state_n  = S_WAIT_LO;
        else if (to_cnt == 3'd7)  att_fail = 1'b1;
        else                      to_cnt_n = to_cnt + 3'd1;
      end
      S_WAIT_LO: begin
        if (!busy) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (err || (wr_rd_flag && (rd_data != data_byte))) att_fail = 1'b1;
        else                                               att_pass = 1'b1;
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      S_FAIL: begin
        fail_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Attempt resolution is shared by the busy timeout and the post-transfer check.
    if (att_fail) begin
      if (retry < MAX_R) begin
        retry_n = retry + 8'd1;
        wr_rd_n = 1'b0;
        state_n = S_ISSUE;
      end else begin
        fail_index_n = entry_idx;
        state_n      = S_FAIL;
      end
    end else if (att_pass) begin
      if (VERIFY && !wr_rd_flag) begin
        wr_rd_n = 1'b1;
        state_n = S_ISSUE;
      end else begin
        retry_n = '0;
        wr_rd_n = 1'b0;
        if (entry_idx == LAST_IDX) begin
          state_n = S_DONE;
        end else begin
          entry_idx_n = entry_idx + 8'd1;
          state_n     = S_FETCH;
        end
      end
    end
  end

  assign rom_addr        = entry_idx;
  assign i2c_device_addr = {DEV_ADDR[7:1], 1'b0};
  assign cfg_busy        = (state != S_IDLE);
  assign fsm_state       = state;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: two instances (VERIFY off / on) driven by a ROM model and a
// behavioural I2C driver model; issued transactions are scored against an expected queue.
module tb_i2c_cfg_seq;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  cfg_start = '0;
  logic [1:0]  start_en, wr_rd_flag, cfg_busy, cfg_done, cfg_fail;
  logic [1:0]  busy = '0;
  logic [1:0]  err  = '0;
  logic [7:0]  rom_addr [NI];
  logic [7:0]  i2c_device_addr [NI];
  logic [7:0]  data_byte [NI];
  logic [7:0]  fail_index [NI];
  logic [7:0]  rd_data [NI] = '{default: 8'h00};
  logic [23:0] rom_data [NI] = '{default: 24'h0};
  logic [15:0] register [NI];
  logic [3:0]  fsm_state [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      i2c_cfg_seq #(
        .NUM_ENTRIES(2), .DEV_ADDR(8'h79), .MAX_RETRY(3), .PWR_WAIT(5), .VERIFY(g == 1)
      ) dut (
        .clk_i(clk), .rst(rst), .cfg_start(cfg_start[g]),
        .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
        .start_en(start_en[g]), .wr_rd_flag(wr_rd_flag[g]),
        .i2c_device_addr(i2c_device_addr[g]), .register(register[g]),
        .data_byte(data_byte[g]), .busy(busy[g]), .err(err[g]), .rd_data(rd_data[g]),
        .cfg_busy(cfg_busy[g]), .cfg_done(cfg_done[g]), .cfg_fail(cfg_fail[g]),
        .fail_index(fail_index[g]), .fsm_state(fsm_state[g])
      );
    end
  endgenerate

  // Configuration table: entry 0 is the sensor example register, entry 1 a second register.
  logic [23:0] tbl [2] = '{24'h300882, 24'h40105A};
  localparam logic [15:0] ERR_REG = 16'h4010;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ROM: data appears one clock after the address.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) rom_data[g] <= tbl[rom_addr[g][0]];
  end

  // Driver model: busy for 4 cycles after a request, result valid when busy falls.
  int         cnt [NI]     = '{0, 0};
  logic       no_busy [NI] = '{1'b0, 1'b0};
  logic       err_en [NI]  = '{1'b0, 1'b0};
  logic [7:0] last_wr [NI] = '{8'h00, 8'h00};

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NI; g++) begin
        busy[g]    = 1'b0;
        err[g]     = 1'b0;
        cnt[g]     = 0;
        rd_data[g] = 8'h00;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (start_en[g]) begin
          err[g] = 1'b0;
          if (!no_busy[g]) cnt[g] = 5;
        end else if (cnt[g] > 0) begin
          cnt[g]  = cnt[g] - 1;
          busy[g] = (cnt[g] != 0);
          if (cnt[g] == 0) begin
            if (err_en[g] && register[g] == ERR_REG) err[g] = 1'b1;
            else if (wr_rd_flag[g])                  rd_data[g] = last_wr[g];
            else                                     last_wr[g] = data_byte[g];
          end
        end
      end
    end
  end

  // Scoreboard: {wr_rd_flag, register, data_byte} per issued request.
  logic [24:0] exp_q [$];
  int cyc = 0;
  int cur = 0;
  int start_cnt [NI] = '{0, 0};
  int last_cyc [NI]  = '{0, 0};
  int last_gap [NI]  = '{0, 0};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (start_en[g] === 1'b1) begin
        start_cnt[g]++;
        last_gap[g] = cyc - last_cyc[g];
        last_cyc[g] = cyc;
        check("start_while_busy", {31'b0, busy[g]}, 32'd0);
        if (exp_q.size() == 0 || g != cur) begin
          check("unexpected_start", {31'b0, start_en[g]}, 32'd0);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          check("txn", {7'b0, wr_rd_flag[g], register[g], data_byte[g]}, {7'b0, e});
        end
      end
    end
  end

  task automatic push(input logic rd, input int e);
    exp_q.push_back({rd, tbl[e]});
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    cfg_start[g] = 1'b1;
    @(negedge clk);
    cfg_start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (cfg_busy[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("run_end_busy", {31'b0, cfg_busy[g]}, 32'd0);
  endtask

  task automatic reset_checks(input int g);
    check("rst_cfg_busy", {31'b0, cfg_busy[g]}, 32'd0);
    check("rst_cfg_done", {31'b0, cfg_done[g]}, 32'd0);
    check("rst_cfg_fail", {31'b0, cfg_fail[g]}, 32'd0);
    check("rst_start_en", {31'b0, start_en[g]}, 32'd0);
    check("rst_wr_rd",    {31'b0, wr_rd_flag[g]}, 32'd0);
    check("rst_register", {16'b0, register[g]}, 32'd0);
    check("rst_data",     {24'b0, data_byte[g]}, 32'd0);
    check("rst_rom_addr", {24'b0, rom_addr[g]}, 32'd0);
    check("rst_fail_idx", {24'b0, fail_index[g]}, 32'd0);
    check("rst_dev_addr", {24'b0, i2c_device_addr[g]}, 32'h78);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) reset_checks(g);

    // Two writes, no verify, driver ACKs everything.
    cur = 0;
    base = start_cnt[0];
    push(1'b0, 0); push(1'b0, 1);
    pulse_start(0);
    wait_idle(0);
    check("t1_done", {31'b0, cfg_done[0]}, 32'd1);
    check("t1_fail", {31'b0, cfg_fail[0]}, 32'd0);
    check("t1_starts", start_cnt[0] - base, 32'd2);
    check("t1_q_left", exp_q.size(), 32'd0);

    // Write + read-back per entry.
    cur = 1;
    base = start_cnt[1];
    push(1'b0, 0); push(1'b1, 0); push(1'b0, 1); push(1'b1, 1);
    pulse_start(1);
    wait_idle(1);
    check("t2_done", {31'b0, cfg_done[1]}, 32'd1);
    check("t2_fail", {31'b0, cfg_fail[1]}, 32'd0);
    check("t2_starts", start_cnt[1] - base, 32'd4);
    check("t2_q_left", exp_q.size(), 32'd0);

    // NACK on every attempt of entry 1: first try plus three retries.
    cur = 0;
    err_en[0] = 1'b1;
    base = start_cnt[0];
    push(1'b0, 0);
    for (int k = 0; k < 4; k++) push(1'b0, 1);
    pulse_start(0);
    wait_idle(0);
    err_en[0] = 1'b0;
    check("t3_fail", {31'b0, cfg_fail[0]}, 32'd1);
    check("t3_done", {31'b0, cfg_done[0]}, 32'd0);
    check("t3_fail_idx", {24'b0, fail_index[0]}, 32'd1);
    check("t3_starts", start_cnt[0] - base, 32'd5);
    check("t3_q_left", exp_q.size(), 32'd0);

    // Driver never responds: 8-cycle timeout per attempt, retries on entry 0.
    no_busy[0] = 1'b1;
    base = start_cnt[0];
    for (int k = 0; k < 4; k++) push(1'b0, 0);
    pulse_start(0);
    wait_idle(0);
    no_busy[0] = 1'b0;
    check("t4_fail", {31'b0, cfg_fail[0]}, 32'd1);
    check("t4_fail_idx", {24'b0, fail_index[0]}, 32'd0);
    check("t4_starts", start_cnt[0] - base, 32'd4);
    check("t4_retry_gap", last_gap[0], 32'd9);
    check("t4_q_left", exp_q.size(), 32'd0);

    // Reset while the first write is in flight.
    cur = 1;
    base = start_cnt[1];
    push(1'b0, 0); push(1'b1, 0); push(1'b0, 1); push(1'b1, 1);
    pulse_start(1);
    n = 0;
    while (!busy[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_busy_seen", {31'b0, busy[1]}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks(1);
    check("t5_starts_before", start_cnt[1] - base, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    base = start_cnt[1];
    repeat (30) @(negedge clk);
    check("t5_no_start", start_cnt[1] - base, 32'd0);
    check("t5_idle", {31'b0, cfg_busy[1]}, 32'd0);

    // Extra cfg_start pulses during a run are ignored.
    base = start_cnt[1];
    push(1'b0, 0); push(1'b1, 0); push(1'b0, 1); push(1'b1, 1);
    pulse_start(1);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(2, 6)) @(negedge clk);
      cfg_start[1] = 1'b1;
      @(negedge clk);
      cfg_start[1] = 1'b0;
    end
    wait_idle(1);
    check("t6_done", {31'b0, cfg_done[1]}, 32'd1);
    check("t6_starts", start_cnt[1] - base, 32'd4);
    check("t6_q_left", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("t6_stays_idle", {31'b0, cfg_busy[1]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 Parameter NUM_ENTRIES, default 16, number of table entries to execute (1..256).
REQ-002 Parameter DEV_ADDR, default 8'h78, 8-bit device address; bit 0 is ignored.
REQ-003 Parameter MAX_RETRY, default 3, retries per entry after the first attempt fails.
REQ-004 Parameter PWR_WAIT, default 1000, clk_i cycles to wait after cfg_start before the first transaction.
REQ-005 Parameter VERIFY, default 1, enables read-back compare after each write.
REQ-006 clk_i  in  1  single clock; the same clock that drives the I2C driver's clk_i.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 cfg_start  in  1  one-cycle pulse that starts the configuration run; ignored while busy.
REQ-009 rom_addr  out  8  table entry index.
REQ-010 rom_data  in  24  {register[15:0], data[7:0]}; valid exactly one cycle after rom_addr changes.
REQ-011 start_en  out  1  one-cycle request pulse to the I2C driver.
REQ-012 wr_rd_flag  out  1  0 = write, 1 = read; held stable while a transaction is outstanding.
REQ-013 i2c_device_addr  out  8  DEV_ADDR with bit 0 = 0.
REQ-014 register  out  16  driver register address; held stable while a transaction is outstanding.
REQ-015 data_byte  out  8  driver write data; held stable while a transaction is outstanding.
REQ-016 busy  in  1  driver busy.
REQ-017 err  in  1  driver ACK error.
REQ-018 rd_data  in  8  driver read result.
REQ-019 cfg_busy  out  1  run in progress.
REQ-020 cfg_done  out  1  sticky; all entries passed.
REQ-021 cfg_fail  out  1  sticky; run aborted.
REQ-022 fail_index  out  8  entry index that caused the abort.

Function
REQ-023 The FSM SHALL have the states IDLE, PWR, FETCH, LATCH, ISSUE, WAIT_HI, WAIT_LO, CHECK, DONE and FAIL.
REQ-024 IDLE SHALL go to PWR on cfg_start; the same cfg_start SHALL clear cfg_done, cfg_fail, fail_index, the entry index and the retry count.
REQ-025 PWR SHALL count PWR_WAIT cycles and then go to FETCH.
REQ-026 FETCH SHALL drive rom_addr = entry index; LATCH, one cycle later, SHALL capture rom_data into register and data_byte.
REQ-027 ISSUE SHALL assert start_en for exactly one cycle, then go to WAIT_HI.
REQ-028 WAIT_HI SHALL go to WAIT_LO when busy = 1.
REQ-029 If busy stays 0 for 8 cycles after start_en, the attempt SHALL count as failed (timeout).
REQ-030 WAIT_LO SHALL wait for busy = 0, then go to CHECK.
REQ-031 CHECK SHALL fail the attempt if err = 1.
REQ-032 In a read phase, CHECK SHALL also fail the attempt if rd_data != the captured data_byte.
REQ-033 On a passing write with VERIFY = 1, CHECK SHALL set wr_rd_flag = 1 and return to ISSUE for the read phase.
REQ-034 On a passing read phase, or a passing write with VERIFY = 0, CHECK SHALL advance to the next entry.
REQ-035 On a failed attempt with retry count < MAX_RETRY, the FSM SHALL increment the retry count, set wr_rd_flag = 0 and re-issue the write of the same entry.
REQ-036 On a failed attempt with retry count = MAX_RETRY, the FSM SHALL set fail_index = entry index and go to FAIL.
REQ-037 Advancing SHALL reset the retry count to 0 and set wr_rd_flag = 0.
REQ-038 Advancing from entry NUM_ENTRIES-1 SHALL go to DONE; otherwise it SHALL increment the entry index and go to FETCH.
REQ-039 The entry index SHALL never wrap; NUM_ENTRIES = 256 SHALL finish at index 255.
REQ-040 DONE SHALL set cfg_done = 1; FAIL SHALL set cfg_fail = 1; both SHALL return to IDLE on the next cycle.
REQ-041 cfg_busy SHALL be 1 in every state except IDLE.
REQ-042 cfg_start outside IDLE SHALL be ignored.
REQ-043 Only one start_en SHALL be issued per attempt; a new start_en SHALL never be issued while busy = 1.
REQ-044 register, data_byte, wr_rd_flag and i2c_device_addr SHALL NOT change between ISSUE and the end of CHECK.

Reset
REQ-045 When rst is asserted, the FSM SHALL enter IDLE asynchronously.
REQ-046 The reset value of every output SHALL be 0, except i2c_device_addr = {DEV_ADDR[7:1], 1'b0}.
REQ-047 Reset asserted mid-transaction SHALL abandon the run with no further start_en; the driver is reset by the same system reset.
REQ-048 After reset release, no activity SHALL occur until the next cfg_start.

Verification
REQ-049 Bench SHALL cover: NUM_ENTRIES=2, VERIFY=0, driver model ACKs all -> 2 start_en pulses with register/data from the table, then cfg_done=1 and cfg_fail=0.
REQ-050 Bench SHALL cover: VERIFY=1, entry {16'h3008, 8'h82}, model returns rd_data=8'h82 -> write then read (wr_rd_flag=1), then cfg_done=1.
REQ-051 Bench SHALL cover: model err=1 on every attempt of entry 1, MAX_RETRY=3 -> exactly 4 write attempts on entry 1, then cfg_fail=1 and fail_index=1.
REQ-052 Bench SHALL cover: model never raises busy -> timeout 8 cycles after each start_en, retries as in REQ-051, then cfg_fail=1.
REQ-053 Bench SHALL cover: rst pulsed during WAIT_LO of entry 0 -> all outputs at reset values, no start_en until the next cfg_start.
REQ-054 Bench SHALL cover: cfg_start re-pulsed during a run -> ignored; count of start_en pulses unchanged.
